// File: rtl/busy_done_sram_slave.sv
// Memory-side responder for the RE/WE/BUSY/DONE single-word bus: one access at a
// time, BUSY for LATENCY cycles, then a one-cycle DONE with read data.
module busy_done_sram_slave #(
  parameter int WA         = 32,
  parameter int WD         = 32,
  parameter int DEPTH      = 4096,
  parameter int AW         = 12,
  parameter int ADDR_SHIFT = 5,
  parameter int LATENCY    = 3
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic [WA-1:0] MEM_A,
  input  logic          MEM_RE,
  input  logic          MEM_WE,
  input  logic [WD-1:0] MEM_D,
  output logic [WD-1:0] MEM_Q,
  output logic          MEM_BUSY,
  output logic          MEM_DONE,
  input  logic          LD_WE,
  input  logic [AW-1:0] LD_A,
  input  logic [WD-1:0] LD_D,
  output logic [15:0]   RD_CNT,
  output logic [15:0]   WR_CNT,
  output logic          ERR
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          op_wr;
  logic          op_oor;
  logic [AW-1:0] idx;
  logic [WD-1:0] wdata;
  logic [WD-1:0] mem [DEPTH];

  logic [WA-1:0] full_idx;
  logic          req_oor;
  logic          commit;

  // Any index at or beyond DEPTH (including stray high address bits) is out of range.
  assign full_idx = MEM_A >> ADDR_SHIFT;
  assign req_oor  = full_idx >= WA'(DEPTH);
  assign commit   = (state == S_WAIT) && (cnt == 4'd0);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      op_oor   <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      MEM_Q    <= '0;
      MEM_BUSY <= 1'b0;
      MEM_DONE <= 1'b0;
      RD_CNT   <= '0;
      WR_CNT   <= '0;
      ERR      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; every register samples the pre-edge values.
      MEM_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MEM_RE || MEM_WE) begin
            state    <= S_WAIT;
            cnt      <= 4'(LATENCY - 1);
            op_wr    <= MEM_WE;
            op_oor   <= req_oor;
            idx      <= full_idx[AW-1:0];
            wdata    <= MEM_D;
            MEM_BUSY <= 1'b1;
            if ((MEM_RE && MEM_WE) || req_oor) ERR <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state    <= S_IDLE;
            MEM_BUSY <= 1'b0;
            MEM_DONE <= 1'b1;
            if (op_wr) begin
              WR_CNT <= WR_CNT + 16'd1;
            end else begin
              RD_CNT <= RD_CNT + 16'd1;
              MEM_Q  <= op_oor ? '0 : mem[idx];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive RST_X and it maps onto plain storage.
  // The bus commit is assigned last so it overrides a same-index backdoor write.
  always_ff @(posedge CLK) begin
    if (LD_WE) mem[LD_A] <= LD_D;
    if (commit && op_wr && !op_oor) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_busy_done_sram_slave.sv
// Directed bench for busy_done_sram_slave: a vector table of bus accesses plus
// hand-written sequences for held requests, back-to-back timing, backdoor and reset.
module tb_busy_done_sram_slave;

  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_d = '0;
  logic [31:0] mem_q;
  logic        mem_busy;
  logic        mem_done;
  logic        ld_we = 1'b0;
  logic [11:0] ld_a = '0;
  logic [31:0] ld_d = '0;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  busy_done_sram_slave #(.LATENCY(LATENCY)) dut (
    .CLK(clk), .RST_X(rst_x),
    .MEM_A(mem_a), .MEM_RE(mem_re), .MEM_WE(mem_we), .MEM_D(mem_d),
    .MEM_Q(mem_q), .MEM_BUSY(mem_busy), .MEM_DONE(mem_done),
    .LD_WE(ld_we), .LD_A(ld_a), .LD_D(ld_d),
    .RD_CNT(rd_cnt), .WR_CNT(wr_cnt), .ERR(err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_q;
    logic        exp_err;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Called just after a negedge; the write lands on the following posedge.
  task automatic backdoor(input logic [11:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // One bus access; the request stays asserted for 'hold' cycles after BUSY is seen.
  task automatic access(input logic re, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input string name,
                        output logic [31:0] q_got);
    bit seen = 0;
    bit done_seen = 0;
    int busy_n = 0;
    mem_re = re; mem_we = we; mem_a = a; mem_d = d;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (mem_busy) seen = 1;
    end
    check({name, " accept"}, 32'(seen), 32'd1);
    busy_n = 1;
    if (hold == 0) begin mem_re = 1'b0; mem_we = 1'b0; end
    for (int k = 1; k < 20 && !done_seen; k++) begin
      @(negedge clk);
      if (k >= hold) begin mem_re = 1'b0; mem_we = 1'b0; end
      if (mem_done) done_seen = 1;
      else if (mem_busy) busy_n++;
    end
    mem_re = 1'b0; mem_we = 1'b0;
    check({name, " done"}, 32'(done_seen), 32'd1);
    check({name, " busy cycles"}, 32'(busy_n), 32'(LATENCY));
    check({name, " busy low at done"}, 32'(mem_busy), 32'd0);
    q_got = mem_q;
    @(negedge clk);
    check({name, " done one cycle"}, 32'(mem_done), 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    logic [7:0]  busy_pat;
    logic [7:0]  done_pat;
    int          quiet;

    vecs[0]  = '{1'b1, 1'b0, 32'd0,         32'd0,  32'd5,     1'b0, 16'd1, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'd32768,     32'd0,  32'd7,     1'b0, 16'd2, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'd65536,     32'd12, 32'd7,     1'b0, 16'd2, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 32'd65536,     32'd0,  32'd12,    1'b0, 16'd3, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 32'd65541,     32'd0,  32'd12,    1'b0, 16'd4, 16'd1};
    vecs[5]  = '{1'b1, 1'b1, 32'd64,        32'd9,  32'd12,    1'b1, 16'd4, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'd64,        32'd0,  32'd9,     1'b1, 16'd5, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 32'd160000,    32'd0,  32'd0,     1'b1, 16'd6, 16'd2};
    vecs[8]  = '{1'b0, 1'b1, 32'd160000,    32'd55, 32'd0,     1'b1, 16'd6, 16'd3};
    vecs[9]  = '{1'b1, 1'b0, 32'h8000_0000, 32'd0,  32'd0,     1'b1, 16'd7, 16'd3};
    vecs[10] = '{1'b0, 1'b1, 32'h8000_0080, 32'd77, 32'd0,     1'b1, 16'd7, 16'd4};
    vecs[11] = '{1'b1, 1'b0, 32'd128,       32'd0,  32'h44,    1'b1, 16'd8, 16'd4};
    vecs[12] = '{1'b1, 1'b0, 32'd28928,     32'd0,  32'hABC,   1'b1, 16'd9, 16'd4};

    // Reset state
    #12;
    check("reset busy", 32'(mem_busy), 32'd0);
    check("reset done", 32'(mem_done), 32'd0);
    check("reset q", mem_q, 32'd0);
    check("reset rd_cnt", 32'(rd_cnt), 32'd0);
    check("reset wr_cnt", 32'(wr_cnt), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);

    backdoor(12'd0, 32'd5);
    backdoor(12'd1024, 32'd7);
    backdoor(12'd4, 32'h44);
    backdoor(12'd904, 32'hABC);

    for (int i = 0; i < 13; i++) begin
      access(vecs[i].re, vecs[i].we, vecs[i].a, vecs[i].d, 0, $sformatf("vec%0d", i), q);
      check($sformatf("vec%0d q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d rd_cnt", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
    end

    // Request held two cycles into WAIT: still a single access
    access(1'b1, 1'b0, 32'd0, 32'd0, 2, "hold", q);
    check("hold q", q, 32'd5);
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!mem_busy && !mem_done) quiet++;
    end
    check("hold no second access", 32'(quiet), 32'd3);
    check("hold rd_cnt", 32'(rd_cnt), 32'd10);

    // Continuous request: back-to-back spacing of LATENCY+1
    mem_re = 1'b1; mem_a = 32'd128;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busy_pat[i] = mem_busy;
      done_pat[i] = mem_done;
    end
    mem_re = 1'b0;
    check("b2b busy pattern", 32'(busy_pat), 32'h77);
    check("b2b done pattern", 32'(done_pat), 32'h88);
    check("b2b rd_cnt", 32'(rd_cnt), 32'd12);
    check("b2b q", mem_q, 32'h44);
    @(negedge clk);

    // Backdoor during WAIT: other index lands, same-index collision loses to the bus
    mem_we = 1'b1; mem_a = 32'd320; mem_d = 32'd100;
    @(negedge clk);
    check("ld accept", 32'(mem_busy), 32'd1);
    mem_we = 1'b0;
    ld_we = 1'b1; ld_a = 12'd11; ld_d = 32'd300;
    @(negedge clk);
    ld_we = 1'b0;
    @(negedge clk);
    ld_we = 1'b1; ld_a = 12'd10; ld_d = 32'd200;
    @(negedge clk);
    ld_we = 1'b0;
    check("ld commit done", 32'(mem_done), 32'd1);
    @(negedge clk);
    check("ld wr_cnt", 32'(wr_cnt), 32'd5);
    access(1'b1, 1'b0, 32'd320, 32'd0, 0, "ld collide", q);
    check("ld collide q", q, 32'd100);
    access(1'b1, 1'b0, 32'd352, 32'd0, 0, "ld wait", q);
    check("ld wait q", q, 32'd300);
    check("ld rd_cnt", 32'(rd_cnt), 32'd14);

    // Reset mid-WAIT aborts a pending write
    backdoor(12'd3, 32'd1);
    mem_we = 1'b1; mem_a = 32'd96; mem_d = 32'd3;
    @(negedge clk);
    check("rst accept", 32'(mem_busy), 32'd1);
    mem_we = 1'b0;
    rst_x = 1'b0;
    #1;
    check("rst busy", 32'(mem_busy), 32'd0);
    check("rst done", 32'(mem_done), 32'd0);
    check("rst rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 32'd96, 32'd0, 0, "rst read", q);
    check("rst read q", q, 32'd1);
    check("rst read rd_cnt", 32'(rd_cnt), 32'd1);
    check("rst read wr_cnt", 32'(wr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/busy_done_sram_slave.md
Name: busy_done_sram_slave

Overview:
- Memory-side responder for the RE/WE/BUSY/DONE single-word memory bus used by the vector compute engines.
- Sits directly downstream of the engine master. It accepts one read or write at a time, holds BUSY for a programmable latency, then pulses DONE with read data valid.
- Backed by a word-addressed register array. A backdoor load port lets the bench preload operands, and status counters support checking.

Parameters:
- WA, 32: address width.
- WD, 32: data width.
- DEPTH, 4096: number of words in the array.
- AW, 12: array index width, log2(DEPTH).
- ADDR_SHIFT, 5: right shift from bus address to word index. Engines step addresses by 32.
- LATENCY, 3: cycles BUSY stays high per access. Must be 1..15.

Ports:
- CLK, input, 1: clock, rising edge.
- RST_X, input, 1: asynchronous active-low reset.
- MEM_A, input, WA: request address.
- MEM_RE, input, 1: read request, level; master holds it until it sees BUSY.
- MEM_WE, input, 1: write request, level; master holds it until it sees BUSY.
- MEM_D, input, WD: write data.
- MEM_Q, output, WD: read data, valid in the DONE cycle and held until the next read completes.
- MEM_BUSY, output, 1: access in progress.
- MEM_DONE, output, 1: one-cycle completion pulse.
- LD_WE, input, 1: backdoor write strobe.
- LD_A, input, AW: backdoor word index.
- LD_D, input, WD: backdoor data.
- RD_CNT, output, 16: completed reads; wraps at 16'hFFFF to 0.
- WR_CNT, output, 16: completed writes; wraps at 16'hFFFF to 0.
- ERR, output, 1: sticky error flag.

Behaviour:
- Reset (RST_X low, asynchronous):
  - MEM_BUSY=0, MEM_DONE=0, MEM_Q=0, RD_CNT=0, WR_CNT=0, ERR=0, state=IDLE.
  - Array contents are not reset.
  - Reset during WAIT aborts the access; a pending write is never committed.
- State machine has two states: IDLE and WAIT.
- IDLE:
  - At a rising edge with MEM_RE|MEM_WE high, capture op, index=(MEM_A>>ADDR_SHIFT), and MEM_D.
  - Set BUSY<=1, load the latency counter with LATENCY-1, and go to WAIT.
  - Otherwise hold.
- WAIT:
  - Request inputs are ignored.
  - Decrement the counter each edge.
  - At the edge where the counter is 0:
    - BUSY<=0, DONE<=1, go to IDLE.
    - Read: MEM_Q<=array[index]; RD_CNT+1.
    - Write: array[index]<=captured data; WR_CNT+1; MEM_Q unchanged.
- DONE is high for exactly one cycle; the edge after it clears DONE.
- Timing: for a request accepted at edge k, BUSY is high after edges k..k+LATENCY-1, DONE is high after edge k+LATENCY, and a new request is accepted no earlier than edge k+LATENCY+1. Back-to-back spacing is LATENCY+1 cycles.
- Simultaneous MEM_RE and MEM_WE at acceptance: treated as a write, ERR<=1.
- Out of range (index >= DEPTH, or any MEM_A bits beyond AW+ADDR_SHIFT set):
  - Normal BUSY/DONE timing is kept.
  - Read returns MEM_Q=0; write is dropped.
  - Counters still increment; ERR<=1.
- Misaligned address (low ADDR_SHIFT bits nonzero): low bits are ignored, no error.
- Backdoor port:
  - LD_WE writes array[LD_A]<=LD_D at the edge, in any state.
  - If it coincides with a bus-write commit to the same index, the bus write wins.
  - LD writes do not touch the counters.
- ERR clears only on reset.

Test Plan:
- Preload word 0=5 and word 1024=7 via LD; master reads A=0 with LATENCY=3 -> BUSY high 3 cycles, DONE one cycle with MEM_Q=5, RD_CNT=1.
- Write A=32*2048 with D=12, then read the same address -> second DONE gives MEM_Q=12; WR_CNT=1, RD_CNT=1.
- Hold MEM_RE high for 2 extra cycles after BUSY -> exactly one access, one DONE pulse; the next access is accepted only after DONE.
- Assert MEM_RE and MEM_WE together with A=64, D=9 -> write performed, ERR=1; a later read of A=64 returns 9.
- Read A=32*5000 -> DONE after LATENCY, MEM_Q=0, ERR=1; write to the same address -> array unchanged.
- Assert reset mid-WAIT of a write of D=3 to A=96 (preloaded 1) -> BUSY/DONE=0 immediately; a later read of A=96 returns 1; counters=0.
